alu_seq: RTL

- Parametrised, registered successor to the multi-cycle CPU's combinational ALU.
- Adds flag-register ownership (CZN), carry/borrow-chained ops, SUB/XOR, and an iterative shift-add multiplier.
- Start/done handshake lets the controller FSM issue an operation and wait on done instead of fixed timing.
- Sits between the register-file read latches and the result/flag write-back path.

---
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with owned C/Z/N flags, carry/borrow-chained
// arithmetic and an iterative shift-add multiplier behind a start/done
// handshake. Single-cycle ops complete on the accepting edge; MUL takes
// WIDTH further edges, during which start is ignored.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_we,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       czn,
  output logic             busy,
  output logic             done
);

  // Opcode encoding shared with the controller FSM.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Controller states.
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MUL_RUN = 1'b1;

  // Iteration counter sized to index every multiplier bit.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // One-bit-wider result so bit WIDTH carries the carry-out or the borrow.
  function automatic logic [WIDTH:0] alu_core(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] f_a,
    input logic [WIDTH-1:0] f_b,
    input logic             f_cin
  );
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] ext_c;
    logic [WIDTH:0] res;
    ext_a = {1'b0, f_a};
    ext_b = {1'b0, f_b};
    ext_c = {{WIDTH{1'b0}}, f_cin};
    case (f_op)
      OP_ADD:  res = ext_a + ext_b;
      OP_ADC:  res = ext_a + ext_b + ext_c;
      // Bit WIDTH of the extended difference is set exactly when it borrows.
      OP_SUB:  res = ext_a - ext_b;
      OP_SBB:  res = ext_a - ext_b - ext_c;
      OP_AND:  res = {1'b0, f_a & f_b};
      OP_OR:   res = {1'b0, f_a | f_b};
      OP_XOR:  res = {1'b0, f_a ^ f_b};
      default: res = {(WIDTH+1){1'b0}};
    endcase
    return res;
  endfunction

  // Pack flags as {N, Z, C}; N is the sign bit, not an unsigned compare.
  function automatic logic [2:0] mk_czn(
    input logic [WIDTH-1:0] f_res,
    input logic             f_c
  );
    return {f_res[WIDTH-1], (f_res == {WIDTH{1'b0}}), f_c};
  endfunction

  logic [0:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2:0]         op_q,     op_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic               fwe_q,    fwe_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         czn_q,    czn_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic [WIDTH:0]     alu_out_s;
  logic [2*WIDTH-1:0] addend_s;
  logic [2*WIDTH-1:0] prod_step_s;

  // Single-cycle datapath works on the live inputs of the accepting edge;
  // ADC/SBB chain the carry that is registered at that same edge.
  always_comb begin
    alu_out_s = alu_core(op, a, b, czn_q[0]);
  end

  // One shift-add step: add the latched multiplicand weighted by the
  // current bit position when the next multiplier bit (LSB first) is set.
  always_comb begin
    if (b_q[0]) begin
      addend_s = {{WIDTH{1'b0}}, a_q} << cnt_q;
    end else begin
      addend_s = {(2*WIDTH){1'b0}};
    end
    prod_step_s = prod_q + addend_s;
  end

  // Next-state logic: accept in IDLE only, run the multiplier in MUL_RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    fwe_d    = fwe_q;
    prod_d   = prod_q;
    result_d = result_q;
    czn_d    = czn_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          a_d   = a;
          b_d   = b;
          fwe_d = flag_we;
          if (op == OP_MUL) begin
            if (MUL_EN != 0) begin
              state_d = S_MUL_RUN;
              busy_d  = 1'b1;
              prod_d  = {(2*WIDTH){1'b0}};
              cnt_d   = CNT_ZERO;
            end else begin
              // Multiplier absent: acknowledge, leave result and flags alone.
              done_d = 1'b1;
            end
          end else begin
            result_d = alu_out_s[WIDTH-1:0];
            if (flag_we) begin
              czn_d = mk_czn(alu_out_s[WIDTH-1:0], alu_out_s[WIDTH]);
            end else begin
              czn_d = czn_q;
            end
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_RUN: begin
        if (op_q == OP_MUL) begin
          prod_d = prod_step_s;
          b_d    = {1'b0, b_q[WIDTH-1:1]};
          if (cnt_q == CNT_LAST) begin
            result_d = prod_step_s[WIDTH-1:0];
            if (fwe_q) begin
              czn_d = mk_czn(prod_step_s[WIDTH-1:0],
                             (prod_step_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}));
            end else begin
              czn_d = czn_q;
            end
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Unreachable with a consistent latch; fall back to IDLE silently.
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset abandons any multiply without done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      op_q     <= 3'b000;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      fwe_q    <= 1'b0;
      prod_q   <= {(2*WIDTH){1'b0}};
      result_q <= {WIDTH{1'b0}};
      czn_q    <= 3'b000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fwe_q    <= fwe_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      czn_q    <= czn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign czn    = czn_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
